// File: rtl/irr_pkg.sv
// Shared definitions for the 8259A-compatible interrupt request register.
// Width default, LTIM encodings and the request-vector type.
package irr_pkg;

    localparam int NUM_IRQ = 8;

    localparam logic LTIM_EDGE  = 1'b0;
    localparam logic LTIM_LEVEL = 1'b1;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;

endpackage : irr_pkg

// File: rtl/irr_bit_cell.sv
// One IR channel: previous-level flop, rising-edge detect, request flop and clear.
// prevLevel resets high so a line held high through reset never looks like a fresh edge.
module irr_bit_cell
    import irr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sensitivityMode,
    input  logic level,
    input  logic clearRequest,
    output logic interruptRequest
);

    logic prevLevel;
    logic risingEdge;
    logic nextRequest;

    assign risingEdge = level & ~prevLevel;

    // A new edge wins over a same-cycle clear; a held request drops if the line falls.
    always_comb begin
        nextRequest = 1'b0;
        if (sensitivityMode == LTIM_LEVEL) begin
            nextRequest = level;
        end else begin
            nextRequest = risingEdge | (interruptRequest & level & ~clearRequest);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevLevel        <= 1'b1;
            interruptRequest <= 1'b0;
        end else begin
            prevLevel        <= level;
            interruptRequest <= nextRequest;
        end
    end

endmodule : irr_bit_cell

// File: rtl/interrupt_request_register.sv
// Interrupt Request Register: captures IR0..IR7 in edge or level mode for the priority resolver.
// Optional IRR_SYNC_EN adds a 2-flop input synchronizer (latency 3 clocks instead of 1).
module interrupt_request_register
    import irr_pkg::*;
#(
    parameter int NUM_IRQ = irr_pkg::NUM_IRQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensitivityMode,
    input  logic [NUM_IRQ-1:0] peripheralInterrupts,
    input  logic [NUM_IRQ-1:0] clearRequest,
    output logic [NUM_IRQ-1:0] interruptRequest
);

    logic [NUM_IRQ-1:0] level;

`ifdef IRR_SYNC_EN
    logic [NUM_IRQ-1:0] syncStage1;
    logic [NUM_IRQ-1:0] syncStage2;

    // Synchronizer resets high to match prevLevel, so reset cannot fabricate edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncStage1 <= '1;
            syncStage2 <= '1;
        end else begin
            syncStage1 <= peripheralInterrupts;
            syncStage2 <= syncStage1;
        end
    end

    assign level = syncStage2;
`else
    assign level = peripheralInterrupts;
`endif

    for (genvar n = 0; n < NUM_IRQ; n++) begin : gen_cell
        irr_bit_cell u_cell (
            .clk              (clk),
            .reset            (reset),
            .sensitivityMode  (sensitivityMode),
            .level            (level[n]),
            .clearRequest     (clearRequest[n]),
            .interruptRequest (interruptRequest[n])
        );
    end

endmodule : interrupt_request_register

// File: tb/tb_interrupt_request_register.sv
// Directed self-checking bench for interrupt_request_register (default or IRR_SYNC_EN build).
module tb_interrupt_request_register;

`ifdef IRR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset;
    logic       sensitivityMode;
    logic [7:0] peripheralInterrupts;
    logic [7:0] clearRequest;
    logic [7:0] interruptRequest;

    int checkCount;
    int failCount;

    interrupt_request_register #(.NUM_IRQ(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sensitivityMode      (sensitivityMode),
        .peripheralInterrupts (peripheralInterrupts),
        .clearRequest         (clearRequest),
        .interruptRequest     (interruptRequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checkCount           = 0;
        failCount            = 0;
        reset                = 1'b1;
        sensitivityMode      = 1'b0;
        peripheralInterrupts = 8'hFF;
        clearRequest         = 8'h00;

        // Reset with all lines high, edge mode.
        tick(2);
        check_value("reset_state", interruptRequest, 8'h00);
        reset = 1'b0;
        tick(LAT + 2);
        check_value("held_high_no_edge", interruptRequest, 8'h00);
        peripheralInterrupts = 8'h00;
        tick(LAT);
        check_value("all_low", interruptRequest, 8'h00);
        peripheralInterrupts = 8'h08;
        tick(LAT);
        check_value("ir3_rise", interruptRequest, 8'h08);

        // Level mode follows the lines and ignores clears.
        sensitivityMode      = 1'b1;
        peripheralInterrupts = 8'hA5;
        tick(LAT);
        check_value("level_a5", interruptRequest, 8'hA5);
        peripheralInterrupts = 8'h00;
        tick(LAT);
        check_value("level_00", interruptRequest, 8'h00);
        peripheralInterrupts = 8'hA5;
        clearRequest         = 8'hFF;
        tick(LAT);
        check_value("level_clear_ignored", interruptRequest, 8'hA5);
        tick(1);
        check_value("level_clear_ignored2", interruptRequest, 8'hA5);
        clearRequest = 8'h00;

        // Edge mode: IR5 held high, cleared, no re-request until a new edge.
        sensitivityMode      = 1'b0;
        peripheralInterrupts = 8'h00;
        tick(LAT + 1);
        check_value("edge_idle", interruptRequest, 8'h00);
        peripheralInterrupts = 8'h20;
        tick(LAT);
        check_value("ir5_rise", interruptRequest, 8'h20);
        tick(1);
        check_value("ir5_held", interruptRequest, 8'h20);
        clearRequest = 8'h20;
        tick(1);
        clearRequest = 8'h00;
        check_value("ir5_cleared", interruptRequest, 8'h00);
        tick(2);
        check_value("ir5_stays_clear", interruptRequest, 8'h00);
        peripheralInterrupts = 8'h00;
        tick(LAT);
        peripheralInterrupts = 8'h20;
        tick(LAT);
        check_value("ir5_re_rise", interruptRequest, 8'h20);

        // IR1 rises then falls before acknowledge; IR5 falls at the same time.
        peripheralInterrupts = 8'h02;
        tick(LAT);
        check_value("ir1_rise", interruptRequest, 8'h02);
        peripheralInterrupts = 8'h00;
        tick(LAT);
        check_value("ir1_fall_drops", interruptRequest, 8'h00);

        // Edge and clear on IR0 in the same cycle: set wins.
        peripheralInterrupts = 8'h01;
        tick(LAT - 1);
        clearRequest = 8'h01;
        tick(1);
        clearRequest = 8'h00;
        check_value("ir0_set_wins", interruptRequest, 8'h01);
        tick(1);
        check_value("ir0_held", interruptRequest, 8'h01);

        // Level to edge switch keeps high lines without new edges.
        sensitivityMode      = 1'b1;
        peripheralInterrupts = 8'h0F;
        tick(LAT);
        check_value("level_0f", interruptRequest, 8'h0F);
        sensitivityMode = 1'b0;
        tick(1);
        check_value("switch_retain", interruptRequest, 8'h0F);
        clearRequest = 8'h0F;
        tick(1);
        clearRequest = 8'h00;
        check_value("switch_no_new_edge", interruptRequest, 8'h00);

        // Asynchronous reset mid-cycle.
        sensitivityMode      = 1'b1;
        peripheralInterrupts = 8'hC3;
        tick(LAT);
        check_value("level_c3", interruptRequest, 8'hC3);
        #2;
        reset = 1'b1;
        #1;
        check_value("async_reset", interruptRequest, 8'h00);
        #1;
        reset = 1'b0;
        tick(LAT);
        check_value("after_reset_c3", interruptRequest, 8'hC3);

        // IR3 rise latency in edge mode.
        sensitivityMode      = 1'b0;
        peripheralInterrupts = 8'h00;
        tick(LAT + 1);
        check_value("latency_idle", interruptRequest, 8'h00);
        peripheralInterrupts = 8'h08;
        for (int i = 0; i < LAT - 1; i++) begin
            tick(1);
            check_value("latency_early", interruptRequest, 8'h00);
        end
        tick(1);
        check_value("latency_ir3", interruptRequest, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule : tb_interrupt_request_register
